axis_send_msgs: RTL and testbench

Multi-message AXI-Stream packet generator. Stores NUM_MSG constant messages. On each accepted command it emits one selected message, repeated a programmable number of times, optionally separated by idle gap cycles. It sits between test/control logic and any AXI-Stream sink, and generalises the single-string packet sender with message selection, repetition, gaps, error reporting and a registered output stage.

---
 rtl/axis_msg_pkg.sv | 28 ++
 rtl/axis_msg_rom.sv | 46 ++++
 rtl/axis_send_msgs.sv | 197 +++++++++++++++++++
 tb/tb_axis_send_msgs.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_msg_pkg.sv
// Shared types and elaboration-time helpers for the multi-message AXI-Stream sender.
package axis_msg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Legalise a stored message length: 0 becomes 1, oversize becomes max_len.
    function automatic int clamp_len(input int raw, input int max_len);
        if (raw < 1) begin
            return 1;
        end else if (raw > max_len) begin
            return max_len;
        end else begin
            return raw;
        end
    endfunction

    // Bit position of word i of message k inside the packed message store.
    // Messages are right-aligned in their slot, so word 0 sits highest.
    function automatic int word_at(input int k, input int i, input int len,
                                   input int max_len, input int dw);
        return (k * max_len * dw) + ((len - 1 - i) * dw);
    endfunction

endpackage

// File: rtl/axis_msg_rom.sv
// Constant message store: combinational (message, word index) -> (word, length).
module axis_msg_rom
    import axis_msg_pkg::*;
#(
    parameter int                            DW       = 8,
    parameter int                            NUM_MSG  = 4,
    parameter int                            MAX_LEN  = 16,
    parameter logic [NUM_MSG*8-1:0]          MSG_LENS = {NUM_MSG{8'd1}},
    parameter logic [NUM_MSG*MAX_LEN*DW-1:0] MSG_STRS = '0,
    localparam int                           SW       = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1,
    localparam int                           CW       = $clog2(MAX_LEN + 1)
) (
    input  logic [SW-1:0] sel_s,
    input  logic [CW-1:0] idx_s,
    output logic [DW-1:0] data_s,
    output logic [CW-1:0] len_s
);

    logic [DW-1:0] word_tab_s [NUM_MSG][MAX_LEN];
    logic [CW-1:0] len_tab_s  [NUM_MSG];

    for (genvar k = 0; k < NUM_MSG; k++) begin : g_msg
        localparam int LEN_K = clamp_len(int'(MSG_LENS[k*8 +: 8]), MAX_LEN);
        assign len_tab_s[k] = CW'(LEN_K);
        for (genvar i = 0; i < MAX_LEN; i++) begin : g_word
            if (i < LEN_K) begin : g_used
                assign word_tab_s[k][i] = MSG_STRS[word_at(k, i, LEN_K, MAX_LEN, DW) +: DW];
            end else begin : g_pad
                assign word_tab_s[k][i] = '0;
            end
        end
    end

    // One-hot select of the addressed word and message length; unknown indices read as zero.
    always_comb begin
        data_s = '0;
        len_s  = '0;
        for (int k = 0; k < NUM_MSG; k++) begin
            len_s = len_s | ({CW{sel_s == SW'(k)}} & len_tab_s[k]);
            for (int i = 0; i < MAX_LEN; i++) begin
                data_s = data_s | ({DW{(sel_s == SW'(k)) && (idx_s == CW'(i))}} & word_tab_s[k][i]);
            end
        end
    end

endmodule

// File: rtl/axis_send_msgs.sv
// Multi-message AXI-Stream packet generator: one command emits a selected stored
// message reps+1 times with optional idle gaps, through a registered output stage.
module axis_send_msgs
    import axis_msg_pkg::*;
#(
    parameter int                            DW       = 8,
    parameter int                            NUM_MSG  = 4,
    parameter int                            MAX_LEN  = 16,
    parameter logic [NUM_MSG*8-1:0]          MSG_LENS = {NUM_MSG{8'd1}},
    parameter logic [NUM_MSG*MAX_LEN*DW-1:0] MSG_STRS = '0,
    parameter int                            GAP      = 0,
    localparam int                           SW       = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [SW-1:0] i_sel,
    input  logic [7:0]    i_reps,
    output logic          o_done,
    output logic          o_err,
    output logic [DW-1:0] o_msg_data,
    output logic          o_msg_last,
    output logic          o_msg_valid,
    input  logic          i_msg_ready
);

    localparam int         CW      = $clog2(MAX_LEN + 1);
    localparam bit         HAS_GAP = (GAP > 0);
    localparam logic [7:0] GAP_M1  = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    state_t        state_r, state_nxt_s;
    logic [SW-1:0] sel_r, sel_nxt_s;
    logic [7:0]    reps_r, reps_nxt_s;
    logic [7:0]    gap_cnt_r, gap_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [DW-1:0] data_r;
    logic          last_r, valid_r, ready_r, done_r, err_r;
    logic          done_nxt_s, err_nxt_s, load_s;

    logic          accept_s, legal_s, hs_s, pkt_end_s, reps_zero_s;
    logic [SW-1:0] rom_sel_s;
    logic [CW-1:0] rom_idx_s, rom_len_s;
    logic [DW-1:0] rom_data_s;

    assign accept_s    = i_valid & ready_r;
    assign legal_s     = (int'(i_sel) < NUM_MSG);
    assign hs_s        = valid_r & i_msg_ready;
    assign pkt_end_s   = hs_s & last_r;
    assign reps_zero_s = (reps_r == 8'd0);
    // While idle the ROM previews the incoming command so word 0 can load on accept.
    assign rom_sel_s   = (state_r == ST_IDLE) ? i_sel : sel_r;

    axis_msg_rom #(
        .DW       (DW),
        .NUM_MSG  (NUM_MSG),
        .MAX_LEN  (MAX_LEN),
        .MSG_LENS (MSG_LENS),
        .MSG_STRS (MSG_STRS)
    ) u_rom (
        .sel_s  (rom_sel_s),
        .idx_s  (rom_idx_s),
        .data_s (rom_data_s),
        .len_s  (rom_len_s)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decision.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && legal_s) begin
                    state_nxt_s = ST_SEND;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (!pkt_end_s) begin
                    state_nxt_s = ST_SEND;
                end else if (reps_zero_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (HAS_GAP) begin
                    state_nxt_s = ST_GAP;
                end else begin
                    state_nxt_s = ST_SEND;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == 8'd0) begin
                    state_nxt_s = ST_SEND;
                end else begin
                    state_nxt_s = ST_GAP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values for counters and the output stage; load_s refreshes the word register.
    always_comb begin
        load_s     = 1'b0;
        rom_idx_s  = '0;
        sel_nxt_s  = sel_r;
        reps_nxt_s = reps_r;
        gap_nxt_s  = gap_cnt_r;
        done_nxt_s = 1'b0;
        err_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && legal_s) begin
                    load_s     = 1'b1;
                    sel_nxt_s  = i_sel;
                    reps_nxt_s = i_reps;
                end else if (accept_s) begin
                    err_nxt_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_SEND: begin
                if (pkt_end_s) begin
                    if (reps_zero_s) begin
                        done_nxt_s = 1'b1;
                    end else begin
                        reps_nxt_s = reps_r - 8'd1;
                        gap_nxt_s  = GAP_M1;
                        load_s     = !HAS_GAP;
                    end
                end else if (hs_s) begin
                    load_s    = 1'b1;
                    rom_idx_s = cnt_r + CW'(1);
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == 8'd0) begin
                    load_s = 1'b1;
                end else begin
                    gap_nxt_s = gap_cnt_r - 8'd1;
                end
            end
            default: load_s = 1'b0;
        endcase
    end

    // Registered datapath and outputs; data/last only move when a new word is loaded.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sel_r     <= '0;
            reps_r    <= 8'd0;
            gap_cnt_r <= 8'd0;
            cnt_r     <= '0;
            data_r    <= '0;
            last_r    <= 1'b0;
            valid_r   <= 1'b0;
            ready_r   <= 1'b1;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            sel_r     <= sel_nxt_s;
            reps_r    <= reps_nxt_s;
            gap_cnt_r <= gap_nxt_s;
            if (load_s) begin
                cnt_r  <= rom_idx_s;
                data_r <= rom_data_s;
                last_r <= (rom_idx_s == (rom_len_s - CW'(1)));
            end else begin
                cnt_r  <= cnt_r;
                data_r <= data_r;
                last_r <= last_r;
            end
            valid_r <= (state_nxt_s == ST_SEND);
            ready_r <= (state_nxt_s == ST_IDLE);
            done_r  <= done_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    assign o_ready     = ready_r;
    assign o_done      = done_r;
    assign o_err       = err_r;
    assign o_msg_data  = data_r;
    assign o_msg_last  = last_r;
    assign o_msg_valid = valid_r;

endmodule

// File: tb/tb_axis_send_msgs.sv
// Directed bench for axis_send_msgs: scoreboarded beats, timing and backpressure checks.
module tb_axis_send_msgs;

    localparam logic [23:0] LENS = {8'd0, 8'd4, 8'd2};
    localparam logic [95:0] STRS = {24'h000000, 8'h5A, 32'h61626364, 16'h0000, 16'h6869};

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       v_a = 1'b0, v_b = 1'b0;
    logic [1:0] sel_a = 2'd0, sel_b = 2'd0;
    logic [7:0] reps_a = 8'd0, reps_b = 8'd0;
    logic       ready_a = 1'b1, ready_b = 1'b1;
    logic       cmd_rdy_a, cmd_rdy_b, done_a, done_b, err_a, err_b;
    logic       valid_a, valid_b, last_a, last_b;
    logic [7:0] data_a, data_b;

    axis_send_msgs #(.DW(8), .NUM_MSG(3), .MAX_LEN(4), .MSG_LENS(LENS), .MSG_STRS(STRS), .GAP(0)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(v_a), .o_ready(cmd_rdy_a), .i_sel(sel_a), .i_reps(reps_a),
        .o_done(done_a), .o_err(err_a), .o_msg_data(data_a), .o_msg_last(last_a),
        .o_msg_valid(valid_a), .i_msg_ready(ready_a));

    axis_send_msgs #(.DW(8), .NUM_MSG(3), .MAX_LEN(4), .MSG_LENS(LENS), .MSG_STRS(STRS), .GAP(3)) dut_g (
        .i_clk(clk), .i_rst(rst), .i_valid(v_b), .o_ready(cmd_rdy_b), .i_sel(sel_b), .i_reps(reps_b),
        .o_done(done_b), .o_err(err_b), .o_msg_data(data_b), .o_msg_last(last_b),
        .o_msg_valid(valid_b), .i_msg_ready(ready_b));

    int    n_assert = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    done_cnt_a = 0, err_cnt_a = 0, done_cnt_b = 0;
    int    acc_cyc, dcyc, exp_done_a;
    beat_t exp_a[$], exp_b[$];
    int    hs_a[$], hs_b[$];
    logic  prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;
    logic  prev_last = 1'b0;

    // Reference message table, written out independently of the packed parameters.
    logic [7:0] m_word [3][4];
    int         m_len  [3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input bit b, input int sel, input int reps);
        beat_t e;
        for (int r = 0; r <= reps; r++) begin
            for (int i = 0; i < m_len[sel]; i++) begin
                e.data = m_word[sel][i];
                e.last = (i == m_len[sel] - 1);
                if (b) exp_b.push_back(e);
                else   exp_a.push_back(e);
            end
        end
    endtask

    task automatic send(input bit b, input logic [1:0] sel, input logic [7:0] reps);
        if (b) begin
            v_b = 1'b1; sel_b = sel; reps_b = reps;
        end else begin
            v_a = 1'b1; sel_a = sel; reps_a = reps;
        end
        tick();
        acc_cyc = cyc;
        v_a = 1'b0; v_b = 1'b0;
        sel_a  = 2'($urandom); reps_a = 8'($urandom);
        sel_b  = 2'($urandom); reps_b = 8'($urandom);
    endtask

    task automatic wait_done(input bit b, input int budget, input string tag, output int dc);
        bit got = 1'b0;
        dc = -1;
        for (int c = 0; c < budget; c++) begin
            tick();
            if ((b ? done_b : done_a) === 1'b1) begin
                got = 1'b1;
                dc  = cyc;
                break;
            end
        end
        check(tag, got, 1'b1);
        if (got) begin
            check({tag, "_ready"}, b ? cmd_rdy_b : cmd_rdy_a, 1'b1);
            tick();
            check({tag, "_pulse"}, b ? done_b : done_a, 1'b0);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard and AXI-Stream hold monitor for the gapless instance.
    always @(negedge clk) begin
        beat_t e;
        if (prev_stall) begin
            check("hold_data", data_a, prev_data);
            check("hold_last", last_a, prev_last);
        end
        if (valid_a && ready_a && !rst) begin
            check("beat_expected_a", exp_a.size() > 0, 1'b1);
            if (exp_a.size() > 0) begin
                e = exp_a.pop_front();
                check("beat_data_a", data_a, e.data);
                check("beat_last_a", last_a, e.last);
            end
            hs_a.push_back(cyc + 1);
        end
        if (done_a) done_cnt_a++;
        if (err_a)  err_cnt_a++;
        prev_stall = valid_a && !ready_a && !rst;
        prev_data  = data_a;
        prev_last  = last_a;
    end

    // Scoreboard for the gapped instance.
    always @(negedge clk) begin
        beat_t e;
        if (valid_b && ready_b && !rst) begin
            check("beat_expected_b", exp_b.size() > 0, 1'b1);
            if (exp_b.size() > 0) begin
                e = exp_b.pop_front();
                check("beat_data_b", data_b, e.data);
                check("beat_last_b", last_b, e.last);
            end
            hs_b.push_back(cyc + 1);
        end
        if (done_b) done_cnt_b++;
    end

    initial begin
        m_word[0] = '{8'h68, 8'h69, 8'h00, 8'h00};
        m_word[1] = '{8'h61, 8'h62, 8'h63, 8'h64};
        m_word[2] = '{8'h5A, 8'h00, 8'h00, 8'h00};
        m_len     = '{2, 4, 1};
        exp_done_a = 0;

        // Reset values.
        rst = 1'b1;
        tick(); tick();
        check("rst_ready", cmd_rdy_a, 1'b1);
        check("rst_valid", valid_a, 1'b0);
        check("rst_last",  last_a, 1'b0);
        check("rst_data",  data_a, 8'h00);
        check("rst_done",  done_a, 1'b0);
        check("rst_err",   err_a, 1'b0);
        check("rst_valid_g", valid_b, 1'b0);
        check("rst_ready_g", cmd_rdy_b, 1'b1);
        rst = 1'b0;
        tick();

        // Single 4-word packet, sink always ready.
        hs_a.delete();
        push_exp(0, 1, 0);
        send(0, 2'd1, 8'd0);
        check("lat_valid", valid_a, 1'b1);
        check("lat_ready", cmd_rdy_a, 1'b0);
        wait_done(0, 50, "abcd_done", dcyc);
        exp_done_a++;
        check("abcd_beats", hs_a.size(), 4);
        if (hs_a.size() == 4) begin
            check("abcd_first", hs_a[0], acc_cyc + 1);
            check("abcd_span", hs_a[3] - hs_a[0], 3);
            check("abcd_done_cyc", dcyc, hs_a[3]);
        end
        check("abcd_empty", exp_a.size(), 0);

        // Illegal selection.
        send(0, 2'd3, 8'd0);
        check("err_pulse", err_a, 1'b1);
        check("err_novalid", valid_a, 1'b0);
        check("err_ready", cmd_rdy_a, 1'b1);
        tick();
        check("err_one_cycle", err_a, 1'b0);
        check("err_novalid2", valid_a, 1'b0);

        // Random backpressure, 5 repetitions of "abcd".
        hs_a.delete();
        push_exp(0, 1, 4);
        send(0, 2'd1, 8'd4);
        begin
            bit got = 1'b0;
            for (int c = 0; c < 600; c++) begin
                ready_a = 1'($urandom_range(0, 1));
                tick();
                if (done_a === 1'b1) begin
                    got = 1'b1;
                    break;
                end
            end
            check("bp_done", got, 1'b1);
        end
        ready_a = 1'b1;
        exp_done_a++;
        check("bp_beats", hs_a.size(), 20);
        check("bp_empty", exp_a.size(), 0);
        tick();

        // Reset in the middle of a packet: only 'a' and 'b' get through.
        exp_a.push_back('{data: 8'h61, last: 1'b0});
        exp_a.push_back('{data: 8'h62, last: 1'b0});
        send(0, 2'd1, 8'd0);
        tick(); tick();
        rst = 1'b1; ready_a = 1'b0;
        tick();
        check("abort_valid", valid_a, 1'b0);
        check("abort_ready", cmd_rdy_a, 1'b1);
        check("abort_done", done_a, 1'b0);
        rst = 1'b0; ready_a = 1'b1;
        tick(); tick(); tick();
        check("abort_empty", exp_a.size(), 0);
        push_exp(0, 1, 0);
        send(0, 2'd1, 8'd0);
        wait_done(0, 50, "restart_done", dcyc);
        exp_done_a++;
        check("restart_empty", exp_a.size(), 0);

        // 256 one-word packets back to back (length field 0 reads as 1).
        hs_a.delete();
        push_exp(0, 2, 255);
        send(0, 2'd2, 8'd255);
        wait_done(0, 400, "reps255_done", dcyc);
        exp_done_a++;
        check("reps255_beats", hs_a.size(), 256);
        if (hs_a.size() == 256) begin
            check("reps255_span", hs_a[255] - hs_a[0], 255);
            check("reps255_done_cyc", dcyc, hs_a[255]);
        end
        check("reps255_empty", exp_a.size(), 0);

        // Gapped instance: "hi" three times with 3 idle cycles between.
        hs_b.delete();
        push_exp(1, 0, 2);
        send(1, 2'd0, 8'd2);
        wait_done(1, 100, "gap_done", dcyc);
        check("gap_beats", hs_b.size(), 6);
        if (hs_b.size() == 6) begin
            check("gap_first", hs_b[0], acc_cyc + 1);
            check("gap_in_pkt0", hs_b[1] - hs_b[0], 1);
            check("gap_between0", hs_b[2] - hs_b[1], 4);
            check("gap_in_pkt1", hs_b[3] - hs_b[2], 1);
            check("gap_between1", hs_b[4] - hs_b[3], 4);
            check("gap_done_cyc", dcyc, hs_b[5]);
        end
        check("gap_empty", exp_b.size(), 0);

        tick(); tick();
        check("done_count_a", done_cnt_a, exp_done_a);
        check("err_count_a", err_cnt_a, 1);
        check("done_count_b", done_cnt_b, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
